// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX pipeline register.
interface id_ex_stage_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 64,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [ADDR_W-1:0] id_rs1, id_rs2, id_rd;
    logic [DATA_W-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [7:0]        id_ctrl;
    logic [3:0]        id_funct;
    logic [ADDR_W-1:0] mem_rd;
    logic              mem_reg_wr;
    logic              ex_flush;
    logic              mem_stall;
    logic              hazard_stall;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [DATA_W-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [7:0]        ex_ctrl;
    logic [3:0]        ex_funct;
    logic [1:0]        ex_fwd_a, ex_fwd_b;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_ctrl, id_funct, mem_rd, mem_reg_wr, ex_flush, mem_stall,
        input  hazard_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_ctrl, ex_funct, ex_fwd_a, ex_fwd_b, bubble_cnt
    );
    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_ctrl, id_funct, mem_rd, mem_reg_wr, ex_flush, mem_stall,
        output hazard_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_ctrl, ex_funct, ex_fwd_a, ex_fwd_b, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbles, flush/freeze and registered forwarding selects.
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 64,
    parameter int CNT_W  = 32
) (
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [ADDR_W-1:0] rs1, rs2, rd;
        logic [DATA_W-1:0] rs1_data, rs2_data, imm;
        logic [7:0]        ctrl;
        logic [3:0]        funct;
        logic [1:0]        fwd_a, fwd_b;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             use_rs2, hazard;
    logic [1:0]       fwd_a, fwd_b;

    // ctrl bits: 7 RegWrite, 6 MemRead, 5 MemWrite, 4 MemtoReg, 3 ALUSrc, 2 Branch, 1:0 ALUOp
    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs, input ex_t ex,
                                           input logic mem_wr, input logic [ADDR_W-1:0] mem_rd);
        return (rs == '0) ? 2'b00 :
               (ex.valid && ex.ctrl[7] && ex.rd == rs) ? 2'b10 :
               (mem_wr && mem_rd == rs) ? 2'b01 : 2'b00;
    endfunction

    always_comb begin
        use_rs2 = !bus.id_ctrl[3] || bus.id_ctrl[5] || bus.id_ctrl[2];
        hazard  = ex_q.valid && ex_q.ctrl[6] && ex_q.rd != '0 && bus.id_valid && !bus.ex_flush &&
                  !bus.mem_stall && (ex_q.rd == bus.id_rs1 || (use_rs2 && ex_q.rd == bus.id_rs2));
        fwd_a   = fwd_sel(bus.id_rs1, ex_q, bus.mem_reg_wr, bus.mem_rd);
        fwd_b   = fwd_sel(bus.id_rs2, ex_q, bus.mem_reg_wr, bus.mem_rd);
        ex_d    = (bus.ex_flush || hazard) ? '0 :
                  bus.mem_stall ? ex_q :
                  '{valid: bus.id_valid, pc: bus.id_pc, rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                    rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data, imm: bus.id_imm,
                    ctrl: bus.id_valid ? bus.id_ctrl : 8'h00, funct: bus.id_funct,
                    fwd_a: fwd_a, fwd_b: fwd_b};
        cnt_d   = (hazard && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.hazard_stall = hazard;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_rs1       = ex_q.rs1;
    assign bus.ex_rs2       = ex_q.rs2;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_rs1_data  = ex_q.rs1_data;
    assign bus.ex_rs2_data  = ex_q.rs2_data;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.ex_funct     = ex_q.funct;
    assign bus.ex_fwd_a     = ex_q.fwd_a;
    assign bus.ex_fwd_b     = ex_q.fwd_b;
    assign bus.bubble_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed stimulus against a rule-level model of the ID/EX register.
module tb_id_ex_stage;
    localparam logic [7:0] C_ADD  = 8'b1000_0010;
    localparam logic [7:0] C_LD   = 8'b1101_1000;
    localparam logic [7:0] C_ADDI = 8'b1000_1010;

    logic clk = 0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if #(.CNT_W(4)) bus ();
    id_ex_stage #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [7:0]  ctrl;
        logic [3:0]  fn;
        logic [1:0]  fa, fb;
    } ex_m_t;

    ex_m_t m, z;
    int    mcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a load in EX whose rd is read by the ID instruction stalls it
    function automatic logic model_hazard();
        logic reads_rs2 = !bus.id_ctrl[3] || bus.id_ctrl[5] || bus.id_ctrl[2];
        logic reads_ld  = (m.rd == bus.id_rs1) || (reads_rs2 && m.rd == bus.id_rs2);
        return m.v && m.ctrl[6] && m.rd != 0 && bus.id_valid && !bus.ex_flush && !bus.mem_stall && reads_ld;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (m.v && m.ctrl[7] && m.rd == r) return 2'b10;
        if (bus.mem_reg_wr && bus.mem_rd == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
        bus.id_valid    = 1;
        bus.id_pc       = {$urandom, $urandom};
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_rs1_data = {$urandom, $urandom};
        bus.id_rs2_data = {$urandom, $urandom};
        bus.id_imm      = {$urandom, $urandom};
        bus.id_ctrl     = ctrl;
        bus.id_funct    = 4'($urandom);
        bus.mem_rd      = 0;
        bus.mem_reg_wr  = 0;
        bus.ex_flush    = 0;
        bus.mem_stall   = 0;
    endtask

    task automatic step();
        logic       hz;
        logic [1:0] fa, fb;
        #1;
        hz = model_hazard();
        fa = model_fwd(bus.id_rs1);
        fb = model_fwd(bus.id_rs2);
        check("hazard_stall", {63'd0, bus.hazard_stall}, {63'd0, hz});
        @(posedge clk);
        if (bus.ex_flush) m = z;
        else if (bus.mem_stall) m = m;
        else if (hz) begin
            m = z;
            mcnt = (mcnt == 15) ? 15 : mcnt + 1;
        end else begin
            m.v = bus.id_valid; m.pc = bus.id_pc; m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
            m.d1 = bus.id_rs1_data; m.d2 = bus.id_rs2_data; m.imm = bus.id_imm;
            m.ctrl = bus.id_valid ? bus.id_ctrl : 8'h00; m.fn = bus.id_funct; m.fa = fa; m.fb = fb;
        end
        #1;
        check("ex_valid", {63'd0, bus.ex_valid}, {63'd0, m.v});
        check("ex_pc", bus.ex_pc, m.pc);
        check("ex_rs1", {59'd0, bus.ex_rs1}, {59'd0, m.rs1});
        check("ex_rs2", {59'd0, bus.ex_rs2}, {59'd0, m.rs2});
        check("ex_rd", {59'd0, bus.ex_rd}, {59'd0, m.rd});
        check("ex_rs1_data", bus.ex_rs1_data, m.d1);
        check("ex_rs2_data", bus.ex_rs2_data, m.d2);
        check("ex_imm", bus.ex_imm, m.imm);
        check("ex_ctrl", {56'd0, bus.ex_ctrl}, {56'd0, m.ctrl});
        check("ex_funct", {60'd0, bus.ex_funct}, {60'd0, m.fn});
        check("ex_fwd_a", {62'd0, bus.ex_fwd_a}, {62'd0, m.fa});
        check("ex_fwd_b", {62'd0, bus.ex_fwd_b}, {62'd0, m.fb});
        check("bubble_cnt", {60'd0, bus.bubble_cnt}, 64'(mcnt));
    endtask

    initial begin
        logic [63:0] hold_pc;
        int          hold_cnt;
        z = '{v: 0, pc: 0, d1: 0, d2: 0, imm: 0, rs1: 0, rs2: 0, rd: 0, ctrl: 0, fn: 0, fa: 0, fb: 0};
        m = z;
        mcnt = 0;
        reset = 1;
        drive(0, 0, 0, 0);
        #12;
        check("rst_valid", {63'd0, bus.ex_valid}, 0);
        check("rst_ctrl", {56'd0, bus.ex_ctrl}, 0);
        check("rst_fwd", {60'd0, bus.ex_fwd_a, bus.ex_fwd_b}, 0);
        check("rst_cnt", {60'd0, bus.bubble_cnt}, 0);
        reset = 0;
        drive(1, 2, 3, C_ADD);
        bus.id_rs1_data = 5;
        bus.id_rs2_data = 7;
        step();
        check("t1_data", {bus.ex_rs1_data[31:0], bus.ex_rs2_data[31:0]}, {32'd5, 32'd7});
        check("t1_fwd", {60'd0, bus.ex_fwd_a, bus.ex_fwd_b}, 0);
        drive(3, 1, 4, C_ADD);
        step();
        check("t2_fwd", {60'd0, bus.ex_fwd_a, bus.ex_fwd_b}, 64'b1000);
        drive(1, 2, 5, C_LD);
        step();
        drive(5, 0, 6, C_ADD);
        #1 check("t3_stall", {63'd0, bus.hazard_stall}, 1);
        step();
        check("t3_bubble", {59'd0, bus.ex_valid, bus.bubble_cnt}, 64'b0_0001);
        bus.mem_rd = 5;
        bus.mem_reg_wr = 1;
        step();
        check("t3_fwd_a", {62'd0, bus.ex_fwd_a}, 64'b01);
        drive(1, 2, 5, C_LD);
        step();
        drive(7, 5, 6, C_ADDI);
        #1 check("t4_addi", {63'd0, bus.hazard_stall}, 0);
        step();
        drive(1, 2, 0, C_LD);
        step();
        drive(0, 0, 6, C_ADD);
        #1 check("t4_x0", {63'd0, bus.hazard_stall}, 0);
        step();
        drive(1, 2, 9, C_ADD);
        step();
        hold_pc = m.pc;
        hold_cnt = mcnt;
        drive(9, 9, 10, C_ADD);
        bus.mem_stall = 1;
        repeat (3) step();
        check("t5_hold", {bus.ex_pc[59:0], bus.bubble_cnt}, {hold_pc[59:0], 4'(hold_cnt)});
        drive(1, 2, 5, C_LD);
        step();
        drive(5, 5, 6, C_ADD);
        bus.ex_flush = 1;
        #1 check("t5_flush_stall", {63'd0, bus.hazard_stall}, 0);
        step();
        check("t5_flush", {59'd0, bus.ex_valid, bus.bubble_cnt}, {59'd0, 1'b0, 4'(hold_cnt)});
        for (int i = 0; i < 300; i++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 8'($urandom));
            bus.id_valid   = $urandom_range(0, 7) != 0;
            bus.ex_flush   = $urandom_range(0, 9) == 0;
            bus.mem_stall  = $urandom_range(0, 7) == 0;
            bus.mem_reg_wr = 1'($urandom);
            bus.mem_rd     = 5'($urandom_range(0, 7));
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 2, 5, C_LD);
            step();
            drive(5, 3, 6, C_ADD);
            step();
            step();
        end
        check("t6_sat", {60'd0, bus.bubble_cnt}, 15);
        drive(1, 2, 5, C_LD);
        step();
        drive(5, 3, 6, C_ADD);
        #1 check("t6_pre_rst", {63'd0, bus.hazard_stall}, 1);
        reset = 1;
        #1;
        check("t6_rst_valid", {63'd0, bus.ex_valid}, 0);
        check("t6_rst_stall", {63'd0, bus.hazard_stall}, 0);
        check("t6_rst_cnt", {60'd0, bus.bubble_cnt}, 0);
        check("t6_rst_ctrl", {56'd0, bus.ex_ctrl}, 0);
        reset = 0;
        m = z;
        mcnt = 0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
